// File: rtl/lsu1c_if.sv
// SRAM-like data bus between the memory stage (master) and the data memory (slave).
// One request is accepted per addr_ok; its data returns later on data_ok.
interface lsu1c_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/lsu1c.sv
// Memory-stage-1 pipeline register: captures the execute bundle, runs one data-bus
// transaction per memory op, stalls the front end meanwhile and presents the load result.
module lsu1c (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        ex_valid,
  input  logic        ex_has_exception,
  input  logic        ex_ls_ena,
  input  logic [3:0]  ex_ls_sel,
  input  logic [31:0] ex_ls_addr,
  input  logic [31:0] ex_rt_data,
  input  logic [31:0] ex_alu_res,
  input  logic [31:0] ex_pc,
  input  logic        ex_w_reg_ena,
  input  logic [4:0]  ex_w_reg_dst,
  input  logic        ex_wb_reg_sel,
  input  logic [1:0]  ex_w_hilo_ena,
  input  logic [31:0] ex_hi_res,
  input  logic [31:0] ex_lo_res,
  lsu1c_if.master     bus,
  output logic        lsu1c_stall_req,
  output logic        lsu1c_valid,
  output logic [31:0] lsu1c_alu_res,
  output logic [31:0] lsu1c_load_data,
  output logic [31:0] lsu1c_pc,
  output logic        lsu1c_w_reg_ena,
  output logic [4:0]  lsu1c_w_reg_dst,
  output logic        lsu1c_wb_reg_sel,
  output logic [1:0]  lsu1c_w_hilo_ena,
  output logic [31:0] lsu1c_hi_res,
  output logic [31:0] lsu1c_lo_res
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t      r_state;
  logic        r_data_req, r_stall_req, r_valid;
  logic [3:0]  r_ls_sel;
  logic [31:0] r_ls_addr, r_rt, r_alu_res, r_pc, r_load_data, r_hi, r_lo;
  logic        r_w_reg_ena, r_wb_reg_sel;
  logic [4:0]  r_w_reg_dst;
  logic [1:0]  r_w_hilo_ena;

  logic w_capture, w_mem;
  assign w_capture = !stall_i && !r_stall_req;
  assign w_mem     = ex_valid && ex_ls_ena && !ex_has_exception && !flush_i;

  function automatic logic [1:0] size_of(input logic [3:0] sel);
    case (sel)
      4'b0000, 4'b0001, 4'b1000: size_of = 2'd0;
      4'b0010, 4'b0011, 4'b1001: size_of = 2'd1;
      default:                   size_of = 2'd2;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [3:0] sel, input logic [31:0] rt);
    case (sel)
      4'b1000: store_data = {4{rt[7:0]}};
      4'b1001: store_data = {2{rt[15:0]}};
      default: store_data = rt;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [3:0] sel, input logic [1:0] a,
                                              input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    b = d[{a, 3'b000} +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (sel)
      4'b0000: load_extend = {{24{b[7]}}, b};
      4'b0001: load_extend = {24'd0, b};
      4'b0010: load_extend = {{16{h[15]}}, h};
      4'b0011: load_extend = {16'd0, h};
      4'b0100: load_extend = d;
      default: load_extend = '0;   // stores return no load value
    endcase
  endfunction

  // NOTE: every register here is state, so all assignments are non-blocking; the
  // flush clear sits last so it overrides a same-edge capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_data_req   <= 1'b0;
      r_stall_req  <= 1'b0;
      r_valid      <= 1'b0;
      r_ls_sel     <= '0;
      r_ls_addr    <= '0;
      r_rt         <= '0;
      r_alu_res    <= '0;
      r_pc         <= '0;
      r_load_data  <= '0;
      r_hi         <= '0;
      r_lo         <= '0;
      r_w_reg_ena  <= 1'b0;
      r_wb_reg_sel <= 1'b0;
      r_w_reg_dst  <= '0;
      r_w_hilo_ena <= '0;
    end else begin
      if (w_capture) begin
        r_valid      <= ex_valid;
        r_ls_sel     <= ex_ls_sel;
        r_ls_addr    <= ex_ls_addr;
        r_rt         <= ex_rt_data;
        r_alu_res    <= ex_alu_res;
        r_pc         <= ex_pc;
        r_load_data  <= '0;
        r_hi         <= ex_hi_res;
        r_lo         <= ex_lo_res;
        r_w_reg_ena  <= ex_w_reg_ena;
        r_wb_reg_sel <= ex_wb_reg_sel;
        r_w_reg_dst  <= ex_w_reg_dst;
        r_w_hilo_ena <= ex_w_hilo_ena;
      end

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_capture) begin
            if (w_mem) begin
              r_state     <= S_REQ;
              r_data_req  <= 1'b1;
              r_stall_req <= 1'b1;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_REQ: begin
          if (bus.data_addr_ok) begin
            r_data_req <= 1'b0;
            r_state    <= flush_i ? S_DRAIN : S_WAIT;
          end else if (flush_i) begin
            r_data_req  <= 1'b0;
            r_stall_req <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (bus.data_data_ok) begin
            r_stall_req <= 1'b0;
            if (flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_state     <= S_DONE;
              r_load_data <= load_extend(r_ls_sel, r_ls_addr[1:0], bus.data_rdata);
            end
          end else if (flush_i) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (bus.data_data_ok) begin
            r_stall_req <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_data_req  <= 1'b0;
          r_stall_req <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase

      if (flush_i) begin
        r_valid      <= 1'b0;
        r_w_reg_ena  <= 1'b0;
        r_w_hilo_ena <= '0;
      end
    end
  end

  assign bus.data_req   = r_data_req;
  assign bus.data_wr    = r_ls_sel[3];
  assign bus.data_size  = size_of(r_ls_sel);
  assign bus.data_addr  = r_ls_addr;
  assign bus.data_wdata = store_data(r_ls_sel, r_rt);

  assign lsu1c_stall_req  = r_stall_req;
  assign lsu1c_valid      = r_valid;
  assign lsu1c_alu_res    = r_alu_res;
  assign lsu1c_load_data  = r_load_data;
  assign lsu1c_pc         = r_pc;
  assign lsu1c_w_reg_ena  = r_w_reg_ena;
  assign lsu1c_w_reg_dst  = r_w_reg_dst;
  assign lsu1c_wb_reg_sel = r_wb_reg_sel;
  assign lsu1c_w_hilo_ena = r_w_hilo_ena;
  assign lsu1c_hi_res     = r_hi;
  assign lsu1c_lo_res     = r_lo;

endmodule

// File: tb/tb_lsu1c.sv
// Scoreboard bench for lsu1c: the driver queues expected results and bus transactions,
// a bus slave answers requests, and two monitors compare whatever the DUT presents.
module tb_lsu1c;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        stall_i = 0, flush_i = 0, ex_valid = 0, ex_has_exception = 0, ex_ls_ena = 0;
  logic [3:0]  ex_ls_sel = 0;
  logic [31:0] ex_ls_addr = 0, ex_rt_data = 0, ex_alu_res = 0, ex_pc = 0;
  logic        ex_w_reg_ena = 0, ex_wb_reg_sel = 0;
  logic [4:0]  ex_w_reg_dst = 0;
  logic [1:0]  ex_w_hilo_ena = 0;
  logic [31:0] ex_hi_res = 0, ex_lo_res = 0;

  logic        lsu1c_stall_req, lsu1c_valid, lsu1c_w_reg_ena, lsu1c_wb_reg_sel;
  logic [31:0] lsu1c_alu_res, lsu1c_load_data, lsu1c_pc, lsu1c_hi_res, lsu1c_lo_res;
  logic [4:0]  lsu1c_w_reg_dst;
  logic [1:0]  lsu1c_w_hilo_ena;

  lsu1c_if bus();

  lsu1c dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .ex_valid(ex_valid), .ex_has_exception(ex_has_exception),
    .ex_ls_ena(ex_ls_ena), .ex_ls_sel(ex_ls_sel), .ex_ls_addr(ex_ls_addr),
    .ex_rt_data(ex_rt_data), .ex_alu_res(ex_alu_res), .ex_pc(ex_pc),
    .ex_w_reg_ena(ex_w_reg_ena), .ex_w_reg_dst(ex_w_reg_dst), .ex_wb_reg_sel(ex_wb_reg_sel),
    .ex_w_hilo_ena(ex_w_hilo_ena), .ex_hi_res(ex_hi_res), .ex_lo_res(ex_lo_res),
    .bus(bus),
    .lsu1c_stall_req(lsu1c_stall_req), .lsu1c_valid(lsu1c_valid),
    .lsu1c_alu_res(lsu1c_alu_res), .lsu1c_load_data(lsu1c_load_data), .lsu1c_pc(lsu1c_pc),
    .lsu1c_w_reg_ena(lsu1c_w_reg_ena), .lsu1c_w_reg_dst(lsu1c_w_reg_dst),
    .lsu1c_wb_reg_sel(lsu1c_wb_reg_sel), .lsu1c_w_hilo_ena(lsu1c_w_hilo_ena),
    .lsu1c_hi_res(lsu1c_hi_res), .lsu1c_lo_res(lsu1c_lo_res)
  );

  typedef struct {
    logic        exc, ena;
    logic [3:0]  sel;
    logic [31:0] addr, rt, alu, pc;
    logic        wreg;
    logic [4:0]  dst;
    logic        wbsel;
    logic [1:0]  hilo;
    logic [31:0] hi, lo;
  } ex_t;

  typedef struct {
    logic [31:0] alu, load, pc, hi, lo;
    logic        wreg, wbsel;
    logic [4:0]  dst;
    logic [1:0]  hilo;
    int          cyc, stalls;
  } res_t;

  typedef struct {
    logic [31:0] addr, wdata;
    logic        wr;
    logic [1:0]  size;
    int          req_cycles;
  } bus_t;

  typedef struct {
    int          addr_dly, data_dly;
    logic [31:0] rdata;
  } rsp_t;

  res_t res_q[$];
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic ex_t mk(input logic exc, input logic ena, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] rt,
                             input logic [31:0] alu, input logic [31:0] pc,
                             input logic wreg, input logic [4:0] dst, input logic wbsel,
                             input logic [1:0] hilo, input logic [31:0] hi,
                             input logic [31:0] lo);
    ex_t x;
    x.exc = exc; x.ena = ena; x.sel = sel; x.addr = addr; x.rt = rt; x.alu = alu;
    x.pc = pc; x.wreg = wreg; x.dst = dst; x.wbsel = wbsel; x.hilo = hilo;
    x.hi = hi; x.lo = lo;
    return x;
  endfunction

  task automatic drive_bubble();
    ex_valid = 0; ex_ls_ena = 0; ex_has_exception = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (lsu1c_stall_req && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (lsu1c_stall_req) begin
      n_vec++;
      n_bad++;
      $display("FAIL stall_timeout: stall still 1 after %0d cycles, expected 0", n);
    end
  endtask

  // Issue one bundle; expected bus fields, load value and latency are given by hand.
  task automatic issue(input ex_t x, input logic is_mem, input logic [1:0] size,
                       input logic [31:0] wdata, input int adly, input int ddly,
                       input logic [31:0] rdata, input logic [31:0] exp_load,
                       input int lat, input int hold);
    res_t e;
    bus_t b;
    rsp_t r;
    @(negedge clk);
    ex_valid = 1; ex_has_exception = x.exc; ex_ls_ena = x.ena; ex_ls_sel = x.sel;
    ex_ls_addr = x.addr; ex_rt_data = x.rt; ex_alu_res = x.alu; ex_pc = x.pc;
    ex_w_reg_ena = x.wreg; ex_w_reg_dst = x.dst; ex_wb_reg_sel = x.wbsel;
    ex_w_hilo_ena = x.hilo; ex_hi_res = x.hi; ex_lo_res = x.lo;
    e.alu = x.alu; e.load = exp_load; e.pc = x.pc; e.hi = x.hi; e.lo = x.lo;
    e.wreg = x.wreg; e.wbsel = x.wbsel; e.dst = x.dst; e.hilo = x.hilo;
    e.cyc = cyc + lat;
    e.stalls = is_mem ? lat - 1 : 0;
    res_q.push_back(e);
    if (is_mem) begin
      b.addr = x.addr; b.wdata = wdata; b.wr = x.sel[3]; b.size = size; b.req_cycles = adly + 1;
      bus_q.push_back(b);
      r.addr_dly = adly; r.data_dly = ddly; r.rdata = rdata;
      rsp_q.push_back(r);
    end
    @(negedge clk);
    drive_bubble();
    if (hold > 0) begin
      stall_i = 1;
      repeat (hold) @(negedge clk);
      #2;
      check("hold_hi", lsu1c_hi_res, x.hi);
      check("hold_lo", lsu1c_lo_res, x.lo);
      check("hold_hilo_ena", 32'(lsu1c_w_hilo_ena), 32'(x.hilo));
      stall_i = 0;
    end
    wait_idle();
  endtask

  // Bus slave: answers each request after the queued addr_ok/data_ok delays.
  initial begin
    rsp_t r;
    bus.data_addr_ok = 0; bus.data_data_ok = 0; bus.data_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst && bus.data_req && rsp_q.size() > 0) begin
        r = rsp_q.pop_front();
        repeat (r.addr_dly) @(negedge clk);
        bus.data_addr_ok = 1;
        @(negedge clk);
        bus.data_addr_ok = 0;
        repeat (r.data_dly) @(negedge clk);
        bus.data_data_ok = 1;
        bus.data_rdata   = r.rdata;
        @(negedge clk);
        bus.data_data_ok = 0;
        bus.data_rdata   = 0;
      end
    end
  end

  // Bus monitor: every cycle with data_req high must match the expected transaction.
  initial begin
    int req_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.data_req) begin
        req_cnt++;
        if (bus_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_req: data_req=1 addr=0x%08h, expected no request", bus.data_addr);
          req_cnt = 0;
        end else begin
          check("bus_addr", bus.data_addr, bus_q[0].addr);
          check("bus_wr", 32'(bus.data_wr), 32'(bus_q[0].wr));
          check("bus_size", 32'(bus.data_size), 32'(bus_q[0].size));
          check("bus_wdata", bus.data_wdata, bus_q[0].wdata);
          if (bus.data_addr_ok) begin
            check("req_cycles", req_cnt, bus_q[0].req_cycles);
            void'(bus_q.pop_front());
            req_cnt = 0;
          end
        end
      end else if (!rst) begin
        req_cnt = 0;
      end
    end
  end

  // Result monitor: the first cycle the stage presents a valid, unstalled instruction.
  initial begin
    res_t e;
    logic prev_present = 0;
    logic present;
    int   stall_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        prev_present = 0;
        stall_cnt = 0;
      end else begin
        present = lsu1c_valid && !lsu1c_stall_req;
        if (lsu1c_stall_req) stall_cnt++;
        else if (!lsu1c_valid) stall_cnt = 0;
        if (present && !prev_present) begin
          if (res_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_result: pc=0x%08h presented, expected none", lsu1c_pc);
          end else begin
            e = res_q.pop_front();
            check("alu_res", lsu1c_alu_res, e.alu);
            check("load_data", lsu1c_load_data, e.load);
            check("pc", lsu1c_pc, e.pc);
            check("w_reg_ena", 32'(lsu1c_w_reg_ena), 32'(e.wreg));
            check("w_reg_dst", 32'(lsu1c_w_reg_dst), 32'(e.dst));
            check("wb_reg_sel", 32'(lsu1c_wb_reg_sel), 32'(e.wbsel));
            check("w_hilo_ena", 32'(lsu1c_w_hilo_ena), 32'(e.hilo));
            check("hi_res", lsu1c_hi_res, e.hi);
            check("lo_res", lsu1c_lo_res, e.lo);
            check("result_cycle", cyc, e.cyc);
            check("stall_cycles", stall_cnt, e.stalls);
          end
          stall_cnt = 0;
        end
        prev_present = present;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus_t b;
    rsp_t r;

    repeat (2) @(negedge clk);
    check("rst_data_req", 32'(bus.data_req), 0);
    check("rst_stall", 32'(lsu1c_stall_req), 0);
    check("rst_valid", 32'(lsu1c_valid), 0);
    check("rst_load_data", lsu1c_load_data, 0);
    check("rst_pc", lsu1c_pc, 0);
    rst = 1;
    @(negedge clk);

    //     exc ena sel      addr          rt            alu           pc            wr dst    wb hilo  hi            lo
    issue(mk(0, 0, 4'b0000, 32'h0,        32'h0,        32'h0000_1234, 32'h0000_0100, 1, 5'd5, 0, 2'b00, 32'h0, 32'h0),
          0, 2'd0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    issue(mk(0, 1, 4'b0000, 32'h0000_1003, 32'h0,       32'h0000_1003, 32'h0000_0104, 1, 5'd8, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd0, 32'h0, 0, 0, 32'h80AA_BBCC, 32'hFFFF_FF80, 3, 0);
    issue(mk(0, 1, 4'b1001, 32'h0000_2002, 32'h0000_BEEF, 32'h0000_2002, 32'h0000_0108, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0),
          1, 2'd1, 32'hBEEF_BEEF, 2, 0, 32'h0, 32'h0, 5, 0);
    issue(mk(0, 1, 4'b0011, 32'h0000_3002, 32'h0,       32'h0000_3002, 32'h0000_010C, 1, 5'd9, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd1, 32'h0, 0, 0, 32'h8001_1234, 32'h0000_8001, 3, 0);
    issue(mk(0, 1, 4'b0100, 32'h0000_4000, 32'h1111_2222, 32'h0000_4000, 32'h0000_0110, 1, 5'd10, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd2, 32'h1111_2222, 0, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4, 0);
    issue(mk(0, 1, 4'b1000, 32'h0000_5001, 32'h1234_56A5, 32'h0000_5001, 32'h0000_0114, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0),
          1, 2'd0, 32'hA5A5_A5A5, 1, 0, 32'h0, 32'h0, 4, 0);
    issue(mk(0, 1, 4'b0010, 32'h0000_6000, 32'h0,       32'h0000_6000, 32'h0000_0118, 1, 5'd11, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd1, 32'h0, 0, 0, 32'h1234_F00D, 32'hFFFF_F00D, 3, 0);
    issue(mk(0, 1, 4'b0001, 32'h0000_7001, 32'h0,       32'h0000_7001, 32'h0000_011C, 1, 5'd12, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd0, 32'h0, 0, 0, 32'h0000_9A00, 32'h0000_009A, 3, 0);
    issue(mk(0, 1, 4'b1010, 32'h0000_7FFC, 32'hCAFE_F00D, 32'h0000_7FFC, 32'h0000_0120, 0, 5'd0, 0, 2'b00, 32'h0, 32'h0),
          1, 2'd2, 32'hCAFE_F00D, 0, 0, 32'h0, 32'h0, 3, 0);
    issue(mk(1, 1, 4'b0100, 32'h0000_8888, 32'h0,       32'h0000_8888, 32'h0000_0124, 1, 5'd13, 1, 2'b00, 32'h0, 32'h0),
          0, 2'd0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    issue(mk(0, 0, 4'b0000, 32'h0,        32'h0,        32'h0000_0077, 32'h0000_0128, 0, 5'd0, 0, 2'b11, 32'hAAAA_0001, 32'h5555_FFFE),
          0, 2'd0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 3);

    // Flush while waiting for data: drain until data_ok, then idle with nothing retired.
    @(negedge clk);
    ex_valid = 1; ex_ls_ena = 1; ex_ls_sel = 4'b0100; ex_ls_addr = 32'h0000_8000;
    ex_rt_data = 0; ex_w_reg_ena = 1; ex_w_reg_dst = 5'd3; ex_w_hilo_ena = 0;
    b.addr = 32'h0000_8000; b.wdata = 0; b.wr = 0; b.size = 2'd2; b.req_cycles = 1;
    bus_q.push_back(b);
    r.addr_dly = 0; r.data_dly = 3; r.rdata = 32'h55AA_55AA;
    rsp_q.push_back(r);
    @(negedge clk);
    drive_bubble();
    @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    #2;
    check("drain_stall", 32'(lsu1c_stall_req), 1);
    check("drain_valid", 32'(lsu1c_valid), 0);
    check("drain_w_reg_ena", 32'(lsu1c_w_reg_ena), 0);
    repeat (2) @(negedge clk);
    #2;
    check("drain_stall_held", 32'(lsu1c_stall_req), 1);
    @(negedge clk);
    #2;
    check("drain_released", 32'(lsu1c_stall_req), 0);
    check("drain_load_data", lsu1c_load_data, 0);
    check("drain_w_reg_ena_after", 32'(lsu1c_w_reg_ena), 0);
    wait_idle();

    // Asynchronous reset in the middle of a transaction.
    @(negedge clk);
    ex_valid = 1; ex_ls_ena = 1; ex_ls_sel = 4'b0100; ex_ls_addr = 32'h0000_9000;
    ex_rt_data = 0; ex_alu_res = 32'h0000_9000; ex_pc = 32'h0000_0200; ex_w_reg_ena = 1;
    b.addr = 32'h0000_9000; b.wdata = 0; b.wr = 0; b.size = 2'd2; b.req_cycles = 1;
    bus_q.push_back(b);
    r.addr_dly = 0; r.data_dly = 4; r.rdata = 32'h1234_5678;
    rsp_q.push_back(r);
    @(negedge clk);
    drive_bubble();
    @(negedge clk);
    #1;
    check("pre_rst_stall", 32'(lsu1c_stall_req), 1);
    rst = 0;
    #1;
    check("async_data_req", 32'(bus.data_req), 0);
    check("async_stall", 32'(lsu1c_stall_req), 0);
    check("async_valid", 32'(lsu1c_valid), 0);
    check("async_alu_res", lsu1c_alu_res, 0);
    check("async_pc", lsu1c_pc, 0);
    check("async_addr", bus.data_addr, 0);
    check("async_w_reg_ena", 32'(lsu1c_w_reg_ena), 0);
    repeat (6) @(negedge clk);
    rst = 1;
    @(negedge clk);
    #2;
    check("post_rst_stall", 32'(lsu1c_stall_req), 0);
    check("post_rst_data_req", 32'(bus.data_req), 0);

    issue(mk(0, 1, 4'b0000, 32'h0000_1000, 32'h0,       32'h0000_1000, 32'h0000_0300, 1, 5'd4, 1, 2'b00, 32'h0, 32'h0),
          1, 2'd0, 32'h0, 0, 0, 32'h0000_007F, 32'h0000_007F, 3, 0);

    repeat (5) @(negedge clk);
    check("res_q_empty", res_q.size(), 0);
    check("bus_q_empty", bus_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu1c.md
# lsu1c

Memory-stage-1 pipeline register and data-bus master directly downstream of the execute stage. Captures the execute bundle, issues at most one SRAM-like data-bus transaction per instruction, stalls the front end until the transaction completes, and presents the aligned and extended load result. It also presents registered HI/LO results that the execute stage forwards through `FORWARD_LS1C_HI` and `FORWARD_LS1C_LO`.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- stall_i  in  1  downstream stall; hold the stage register
- flush_i  in  1  exception/refetch flush from commit
- ex_valid  in  1  execute bundle valid
- ex_has_exception  in  1  bundle carries an exception; suppresses bus access
- ex_ls_ena / ex_ls_sel  in  1/4  memory op enable / op code (bit 3 = store)
- ex_ls_addr / ex_rt_data / ex_alu_res / ex_pc  in  32 each  address, store source, ALU result, PC
- ex_w_reg_ena / ex_w_reg_dst / ex_wb_reg_sel  in  1/5/1  register write-back controls
- ex_w_hilo_ena / ex_hi_res / ex_lo_res  in  2/32/32  HI/LO write controls and data
- data_req / data_wr / data_size  out  1/1/2  bus request, write, size (0 = byte, 1 = half, 2 = word)
- data_addr / data_wdata  out  32/32  bus address, replicated store data
- data_addr_ok / data_data_ok / data_rdata  in  1/1/32  bus address accept, data return, read data
- lsu1c_stall_req  out  1  front-end stall request
- lsu1c_valid  out  1  stage holds a valid instruction
- lsu1c_alu_res / lsu1c_load_data / lsu1c_pc  out  32 each  registered ALU result, extended load value, PC
- lsu1c_w_reg_ena / lsu1c_w_reg_dst / lsu1c_wb_reg_sel  out  1/5/1  registered write-back controls
- lsu1c_w_hilo_ena / lsu1c_hi_res / lsu1c_lo_res  out  2/32/32  registered HI/LO controls and data

## Operation
- ls_sel encoding:
  - LB 0000, LBU 0001, LH 0010, LHU 0011, LW 0100
  - SB 1000, SH 1001, SW 1010
- Capture: the stage register loads the `ex_*` bundle when !stall_i & !lsu1c_stall_req. Otherwise it holds.
- Captured op becomes a memory op (mem) when ex_valid & ex_ls_ena & !ex_has_exception & !flush_i.
- FSM states:
  - IDLE
  - REQ: data_req=1
  - WAIT: awaiting data_ok
  - DRAIN: accepted request whose instruction was flushed
  - DONE: result held
- Transitions:
  - IDLE: capture of mem → REQ.
  - REQ: addr_ok & !flush_i → WAIT. addr_ok & flush_i → DRAIN. !addr_ok & flush_i → IDLE (request withdrawn).
  - WAIT: data_ok & !flush_i → DONE. data_ok & flush_i → IDLE. !data_ok & flush_i → DRAIN.
  - DRAIN: data_ok → IDLE. Read data is discarded and every output remains as it was when the flush took effect.
  - DONE: capture of new bundle → REQ if mem, else IDLE.
- lsu1c_stall_req = state ∈ {REQ, WAIT, DRAIN}.
- Bus outputs: data_addr = captured ls_addr (unmodified), data_wr = ls_sel[3], data_size from op.
- Store data:
  - SB → {4{rt[7:0]}}
  - SH → {2{rt[15:0]}}
  - SW → rt
- Load data is latched on data_ok in WAIT:
  - LB/LBU take byte addr[1:0] of rdata, sign- or zero-extended.
  - LH/LHU take half addr[1] of rdata, sign- or zero-extended.
  - LW takes rdata unchanged.
- lsu1c_load_data is 0 for stores.
- flush_i clears lsu1c_valid, lsu1c_w_reg_ena and lsu1c_w_hilo_ena at the next edge, whatever the state.
- An exception bundle is captured with lsu1c_valid=1 but issues no bus access.
- At most one outstanding transaction at any time.

## Timing
- Reset: every output 0, state IDLE. data_req drops asynchronously when rst falls, including mid-transaction. No DRAIN is attempted after reset.
- Non-memory op: one-cycle stage. Outputs are valid the cycle after capture, and lsu1c_stall_req stays 0.
- Load or store with addr_ok and data_ok each asserted on first opportunity:
  - Capture at edge 0.
  - REQ in cycle 1.
  - WAIT in cycle 2.
  - DONE in cycle 3: lsu1c_load_data valid, stall released.
- Each cycle of addr_ok or data_ok delay adds one cycle.
- data_req and all bus outputs are held stable from REQ entry until addr_ok.
- HI/LO outputs are valid from the cycle after capture and held through any stall.

## Test plan
- ALU op: ex_alu_res=0x1234, ex_ls_ena=0 → lsu1c_alu_res=0x1234 one cycle later; lsu1c_stall_req stays 0; data_req never asserted.
- LB with addr=0x1003 and rdata=0x80AABBCC, addr_ok and data_ok immediate → data_size=0 and data_req high for exactly one cycle; lsu1c_load_data=0xFFFFFF80 in cycle 3; stall high for cycles 1-2.
- SH with addr=0x2002 and rt=0x0000BEEF, addr_ok delayed 2 cycles → data_wr=1, data_size=1, data_wdata=0xBEEFBEEF; bus outputs stable until addr_ok; DONE in cycle 5.
- Load in WAIT with flush_i pulsed, data_ok 3 cycles later → state DRAIN, stall held until data_ok, then IDLE; lsu1c_w_reg_ena=0 and lsu1c_load_data unchanged.
- Load with ex_has_exception=1 → no data_req; lsu1c_valid=1 next cycle.
- rst falls while in WAIT → data_req=0 and all outputs 0 immediately; after rst rises, state is IDLE.
